// File: rtl/cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice per clock, start/done handshake.
// Optional subtract mode (adds port sub) is enabled by defining CLA_SERIAL_SUB_EN.
module cla_serial_adder #(
  parameter int WIDTH = 16  // multiple of 4, at least 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NS = WIDTH / 4;
  localparam int IW = $clog2(NS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, wsum_q, wsum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d, done_q, done_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [3:0]       p, g, c, slice_sum;
  logic             grp_p, grp_g, carry_next;
  logic [WIDTH-1:0] wsum_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Operands shift right one slice per cycle, so the active slice is always bits [3:0].
  always_comb begin
    p = a_q[3:0] ^ b_q[3:0];
    g = a_q[3:0] & b_q[3:0];
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & carry_q);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
    carry_next = grp_g | (grp_p & carry_q);
    slice_sum = p ^ c;
    wsum_next = {slice_sum, wsum_q[WIDTH-1:4]};
  end

`ifdef CLA_SERIAL_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub | cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    wsum_d  = wsum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          idx_d   = '0;
          wsum_d  = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        wsum_d  = wsum_next;
        carry_d = carry_next;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          // c[3] of the top slice is the carry into the MSB.
          sum_d   = wsum_next;
          cout_d  = carry_next;
          ovf_d   = c[3] ^ carry_next;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      wsum_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wsum_q  <= wsum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Scoreboard bench for cla_serial_adder: directed cases plus random operands against an arithmetic model.
module tb_cla_serial_adder;
  localparam int W  = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
`ifdef CLA_SERIAL_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  cla_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef CLA_SERIAL_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, failures = 0, issued = 0, completions = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    exp_t   m;
    longint ua, ub, sa, sb, r, sr;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (ms) begin
      r = ua - ub;
      sr = sa - sb;
      m.cout = (ua >= ub);
    end else begin
      r = ua + ub + longint'(mc);
      sr = sa + sb + longint'(mc);
      m.cout = (r >= (longint'(1) << W));
    end
    m.sum = r[W-1:0];
    m.ovf = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      completions++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 t=%0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  // Drive start for one edge while the adder is not busy (IDLE or DONE) and record the expectation.
  task automatic drive_start(input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic ic, input logic is);
    a = ia; b = ib; cin = ic;
`ifdef CLA_SERIAL_SUB_EN
    sub = is;
`endif
    start = 1'b1;
    sbq.push_back(model(ia, ib, ic, is));
    issued++;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic is);
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=1 expected=0 t=%0t", $time);
    end
    drive_start(ia, ib, ic, is);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 expected=1 t=%0t", $time);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           n;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;

    // Basic add with cycle-accurate latency.
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    for (int i = 1; i <= NS; i++) begin
      @(negedge clk);
      chk("lat_busy", 32'(busy), 1);
      chk("lat_done", 32'(done), 0);
    end
    @(negedge clk);
    chk("lat_done_pulse", 32'(done), 1);
    chk("lat_busy_low", 32'(busy), 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);

    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_done();
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0); wait_done();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_done();
    issue(16'h8000, 16'h8000, 1'b0, 1'b0); wait_done();

    // Start during RUN is ignored; start in the DONE cycle is accepted back-to-back.
    issue(16'h0001, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h00FF; b = 16'h00FF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    chk("hs_sum_first", 32'(sum), 32'h0003);
    drive_start(16'h0010, 16'h0020, 1'b0, 1'b0);
    for (int i = 0; i < NS; i++) begin
      @(negedge clk);
      chk("hs_sum_hold", 32'(sum), 32'h0003);
      chk("hs_busy", 32'(busy), 1);
    end
    wait_done();

    // Reset in the second RUN cycle aborts the operation.
    issue(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(cout), 0);
    chk("abort_ovf", 32'(ovf), 0);
    void'(sbq.pop_back());
    issued--;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * NS; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 0);
    end
    issue(16'h0100, 16'h0100, 1'b0, 1'b0); wait_done();

`ifdef CLA_SERIAL_SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1); wait_done();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1); wait_done();
`endif

    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef CLA_SERIAL_SUB_EN
      rs = 1'($urandom);
`endif
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
      issue(ra, rb, rc, rs);
    end

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("completions", 32'(completions), 32'(issued));
    chk("scoreboard_empty", 32'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_serial_adder.md
Name: cla_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that processes one 4-bit slice per clock.
- Each slice forms per-bit P/G, resolves the four slice carries by lookahead from a registered slice carry-in, and produces the slice sum.
- Slice group-P/G propagate the carry into a carry register for the next cycle.
- Sits in the ALU datapath as the area-reduced alternative to the fully parallel CLA adder; start/done handshake to the controller.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A, latched on accepted start
- b  input  WIDTH  operand B, latched on accepted start
- cin  input  1  carry-in, latched on accepted start
- busy  output  1  high while slices are being processed
- done  output  1  one-cycle pulse: result registers just updated
- sum  output  WIDTH  result, held stable between completions
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow = carry into MSB XOR cout

Behaviour:
- Single clock clk. Reset rst is asynchronous and active-high. While rst=1: state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; working registers cleared.
- NS = WIDTH/4 slices. Slice index counter is ceil(log2(NS)) bits.
- States:
  - IDLE: waiting for start.
  - RUN: processing slices.
  - DONE: one-cycle completion state.
- IDLE with start=1 at edge k:
  - Latch a, b, cin into working registers.
  - Set the carry register to cin and the index to 0.
  - Move to RUN; busy=1 from edge k.
- RUN cycle, slice i (bits 4i+3..4i):
  - p=a^b and g=a&b per bit.
  - c0 = carry register; c1..c3 by lookahead equations, no ripple.
  - Slice sum bit j = p[j]^c[j], written into the working sum register.
  - Carry register <= group-G | (group-P & c0).
  - On the last slice (i=NS-1), also record c3 as carry-into-MSB.
- After the last slice at edge k+NS:
  - Working sum -> sum; final carry -> cout; c3^final carry -> ovf.
  - State=DONE, done=1, busy=0.
  - Completion latency: done is high in the cycle after edge k+NS (5th cycle after accept for WIDTH=16).
- DONE:
  - done=1 for exactly one cycle.
  - start=1 is accepted here as in IDLE (back-to-back, no bubble); otherwise go to IDLE.
- start while busy (RUN): ignored; operands are not re-latched; the in-flight result is unaffected.
- sum, cout and ovf change only on the completion edge. They hold their values through later IDLE/RUN cycles until the next completion.
- Operand inputs may change freely after the accept edge.
- Asserting rst mid-RUN aborts immediately: busy=0 and no done pulse. The first start after deassertion behaves as from power-up.

Optional Feature:
- Macro: CLA_SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands on an accepted start.
  - sub=1: the latched B is ~b and the initial carry is 1 regardless of cin, giving a-b.
  - cout is then the no-borrow flag (1 when a>=b unsigned); ovf is signed overflow of the subtraction.
- Undefined: no sub port; addition only.

Test Plan (WIDTH=16):
- Basic add: start with a=0x1234, b=0x4321, cin=0 -> busy for 4 cycles, done pulse in cycle 5; sum=0x5555, cout=0, ovf=0.
- Carry across slices: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Repeat with a=0xFFFF, b=0x0000, cin=1 -> same result.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Handshake:
  - Pulse start with a=0x0001, b=0x0002, then pulse start with a=0x00FF, b=0x00FF during RUN -> second ignored; sum=0x0003.
  - Start asserted in the DONE cycle with a=0x0010, b=0x0020 -> accepted; next done gives sum=0x0030.
  - sum holds 0x0003 until that completion.
- Reset mid-operation: start a=0xAAAA, b=0x5555, assert rst in the 2nd RUN cycle -> busy=0, done=0, sum=0, cout=0 immediately; no done pulse. After release, a=0x0100, b=0x0100 -> sum=0x0200.
- CLA_SERIAL_SUB_EN defined:
  - a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
